// File: rtl/gesture_pose_ramper_if.sv
// rtl/gesture_pose_ramper_if.sv - gesture handshake and pose-table write bus for the pose ramper
interface gesture_pose_ramper_if #(
  parameter int NUM_CH    = 5,
  parameter int GESTURE_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [GESTURE_W-1:0] gesture;
  logic                 gesture_valid;
  logic                 gesture_ready;
  logic                 tbl_wr_en;
  logic [GESTURE_W-1:0] tbl_wr_pose;
  logic [CH_W-1:0]      tbl_wr_ch;
  logic [15:0]          tbl_wr_data;

  // classifier / host side
  modport master (
    output gesture, gesture_valid, tbl_wr_en, tbl_wr_pose, tbl_wr_ch, tbl_wr_data,
    input  gesture_ready
  );

  // pose engine side
  modport slave (
    input  gesture, gesture_valid, tbl_wr_en, tbl_wr_pose, tbl_wr_ch, tbl_wr_data,
    output gesture_ready
  );
endinterface

// File: rtl/gesture_pose_ramper.sv
// rtl/gesture_pose_ramper.sv - gesture-to-pose servo width engine with rate-limited slewing
module gesture_pose_ramper #(
  parameter int NUM_CH      = 5,
  parameter int GESTURE_W   = 8,
  parameter int NUM_POSES   = 16,
  parameter int NEUTRAL_US  = 1500,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2500,
  parameter int STEP_US     = 20,
  parameter int STEP_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  gesture_pose_ramper_if.slave   bus,
  output logic [NUM_CH*16-1:0]   width_us,
  output logic [GESTURE_W-1:0]   active_pose,
  output logic                   busy,
  output logic                   done
);
  localparam int                CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [15:0]       NEUTRAL16 = 16'(NEUTRAL_US);
  localparam logic [15:0]       MIN16     = 16'(MIN_US);
  localparam logic [15:0]       MAX16     = 16'(MAX_US);
  localparam logic [15:0]       STEP16    = 16'(STEP_US);
  localparam logic [16:0]       STEP17    = 17'(STEP_US);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           cur_q [NUM_CH];
  logic [15:0]           cur_d [NUM_CH];
  logic [15:0]           tgt_q [NUM_CH];
  logic [15:0]           tgt_d [NUM_CH];
  logic [15:0]           tbl_q [NUM_POSES][NUM_CH];
  logic [15:0]           tbl_d [NUM_POSES][NUM_CH];
  logic [GESTURE_W-1:0]  active_pose_q, active_pose_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  code_ok;
  logic                  all_eq;
  logic [15:0]           wr_clamped;

  // One slew step toward the target, never overshooting; 17-bit difference avoids wrap.
  function automatic logic [15:0] step_toward(input logic [15:0] cur, input logic [15:0] tgt);
    logic [16:0] diff;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      return (diff > STEP17) ? cur + STEP16 : tgt;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      return (diff > STEP17) ? cur - STEP16 : tgt;
    end
  endfunction

  assign bus.gesture_ready = (state_q != LOAD);
  assign accept            = bus.gesture_valid && (state_q != LOAD);
  assign code_ok           = (bus.gesture != '0) && (32'(bus.gesture) < NUM_POSES);
  assign wr_clamped        = (bus.tbl_wr_data < MIN16) ? MIN16 :
                             (bus.tbl_wr_data > MAX16) ? MAX16 : bus.tbl_wr_data;

  // All channels settled on their targets
  always_comb begin
    all_eq = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_q[c] != tgt_q[c]) all_eq = 1'b0;
    end
  end

  // Next-state, table write, target load and slew stepping
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_d         = cur_q;
    tgt_d         = tgt_q;
    tbl_d         = tbl_q;
    active_pose_d = active_pose_q;
    done_d        = 1'b0;

    // Entry 0 is the no-op code and is never written; out-of-range pose/ch never match.
    for (int p = 1; p < NUM_POSES; p++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.tbl_wr_en && (32'(bus.tbl_wr_pose) == p) && (32'(bus.tbl_wr_ch) == c)) begin
          tbl_d[p][c] = wr_clamped;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && code_ok) begin
          state_d       = LOAD;
          active_pose_d = bus.gesture;
        end
      end
      LOAD: begin
        // Reads the registered table, so a same-cycle write is seen only on the next load.
        for (int p = 0; p < NUM_POSES; p++) begin
          if (32'(active_pose_q) == p) begin
            for (int c = 0; c < NUM_CH; c++) tgt_d[c] = tbl_q[p][c];
          end
        end
        cnt_d   = '0;
        state_d = RAMP;
      end
      RAMP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          for (int c = 0; c < NUM_CH; c++) cur_d[c] = step_toward(cur_q[c], tgt_q[c]);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A retarget wins over completion, which drops the pending done.
        if (accept && code_ok) begin
          state_d       = LOAD;
          active_pose_d = bus.gesture;
        end else if (all_eq) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset snaps everything to neutral immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      active_pose_q <= '0;
      done_q        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cur_q[c] <= NEUTRAL16;
        tgt_q[c] <= NEUTRAL16;
      end
      for (int p = 0; p < NUM_POSES; p++) begin
        for (int c = 0; c < NUM_CH; c++) tbl_q[p][c] <= NEUTRAL16;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_pose_q <= active_pose_d;
      done_q        <= done_d;
      cur_q         <= cur_d;
      tgt_q         <= tgt_d;
      tbl_q         <= tbl_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pack
    assign width_us[i*16 +: 16] = cur_q[i];
  end

  assign active_pose = active_pose_q;
  assign busy        = (state_q == LOAD) || (state_q == RAMP);
  assign done        = done_q;
endmodule

// File: tb/tb_gesture_pose_ramper.sv
// tb/tb_gesture_pose_ramper.sv - directed self-checking bench for gesture_pose_ramper
module tb_gesture_pose_ramper;
  localparam int NUM_CH = 5;
  localparam int GW     = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_CH*16-1:0] width_us;
  logic [GW-1:0]        active_pose;
  logic                 busy;
  logic                 done;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int d0;

  gesture_pose_ramper_if #(.NUM_CH(NUM_CH), .GESTURE_W(GW)) bus ();

  gesture_pose_ramper #(
    .NUM_CH(NUM_CH), .GESTURE_W(GW), .NUM_POSES(8), .NEUTRAL_US(1500),
    .MIN_US(1000), .MAX_US(2500), .STEP_US(100), .STEP_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .width_us(width_us), .active_pose(active_pose), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // done pulses seen, sampled mid-cycle
  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [31:0] w(input int ch);
    return 32'(width_us[ch*16 +: 16]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] p, input logic [2:0] c, input logic [15:0] d);
    bus.tbl_wr_en   = 1'b1;
    bus.tbl_wr_pose = p;
    bus.tbl_wr_ch   = c;
    bus.tbl_wr_data = d;
    tick();
    bus.tbl_wr_en   = 1'b0;
  endtask

  // Holds valid for one cycle (N); returns in cycle N+1.
  task automatic send(input logic [7:0] code);
    bus.gesture       = code;
    bus.gesture_valid = 1'b1;
    tick();
    bus.gesture_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    bus.gesture       = '0;
    bus.gesture_valid = 1'b0;
    bus.tbl_wr_en     = 1'b0;
    bus.tbl_wr_pose   = '0;
    bus.tbl_wr_ch     = '0;
    bus.tbl_wr_data   = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) chk("rst_width", w(c), 32'd1500);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(bus.gesture_ready), 32'd1);
    chk("rst_active", 32'(active_pose), 32'd0);

    // 2: ramp ch0 1500 -> 1900
    wr(8'd1, 3'd0, 16'd1900);
    send(8'd1);
    chk("t2_load_ready", 32'(bus.gesture_ready), 32'd0);
    chk("t2_load_busy", 32'(busy), 32'd1);
    chk("t2_active", 32'(active_pose), 32'd1);
    ticks(4); chk("t2_pre_step", w(0), 32'd1500);
    tick();   chk("t2_1600", w(0), 32'd1600);
    ticks(4); chk("t2_1700", w(0), 32'd1700);
    ticks(4); chk("t2_1800", w(0), 32'd1800);
    ticks(4); chk("t2_1900", w(0), 32'd1900);
    chk("t2_ch1", w(1), 32'd1500);
    chk("t2_ch4", w(4), 32'd1500);
    chk("t2_busy_end", 32'(busy), 32'd1);
    chk("t2_done_early", 32'(done), 32'd0);
    tick();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_idle", 32'(busy), 32'd0);
    tick();
    chk("t2_done_once", 32'(done), 32'd0);

    // 3: single non-overshooting step, then clamping
    wr(8'd2, 3'd0, 16'd1900);
    wr(8'd2, 3'd1, 16'd1550);
    send(8'd2);
    ticks(4); chk("t3_pre", w(1), 32'd1500);
    tick();   chk("t3_1550", w(1), 32'd1550);
    chk("t3_ch0", w(0), 32'd1900);
    chk("t3_done_early", 32'(done), 32'd0);
    tick();   chk("t3_done", 32'(done), 32'd1);
    wr(8'd2, 3'd1, 16'd900);
    send(8'd2);
    wait_done("t3_lo_done", 100);
    chk("t3_clamp_lo", w(1), 32'd1000);
    wr(8'd2, 3'd1, 16'd2600);
    send(8'd2);
    wait_done("t3_hi_done", 200);
    chk("t3_clamp_hi", w(1), 32'd2500);

    // 4: retarget mid-ramp
    wr(8'd3, 3'd1, 16'd2500);
    send(8'd3);
    wait_done("t4_prep_done", 100);
    chk("t4_prep_ch0", w(0), 32'd1500);
    wr(8'd2, 3'd0, 16'd1300);
    wr(8'd1, 3'd1, 16'd2500);
    send(8'd1);
    ticks(5); chk("t4_up1600", w(0), 32'd1600);
    ticks(4); chk("t4_up1700", w(0), 32'd1700);
    send(8'd2);
    chk("t4_ready_low", 32'(bus.gesture_ready), 32'd0);
    chk("t4_no_snap", w(0), 32'd1700);
    tick();
    chk("t4_ready_back", 32'(bus.gesture_ready), 32'd1);
    d0 = done_cnt;
    ticks(3); chk("t4_hold", w(0), 32'd1700);
    tick();   chk("t4_1600", w(0), 32'd1600);
    ticks(4); chk("t4_1500", w(0), 32'd1500);
    ticks(4); chk("t4_1400", w(0), 32'd1400);
    ticks(4); chk("t4_1300", w(0), 32'd1300);
    chk("t4_no_early_done", 32'(done_cnt - d0), 32'd0);
    chk("t4_ch1", w(1), 32'd2500);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: no-op codes while idle
    tick();
    d0 = done_cnt;
    chk("t5_ready0", 32'(bus.gesture_ready), 32'd1);
    send(8'd0);
    chk("t5_busy0", 32'(busy), 32'd0);
    chk("t5_ready9", 32'(bus.gesture_ready), 32'd1);
    send(8'd9);
    chk("t5_busy9", 32'(busy), 32'd0);
    ticks(3);
    chk("t5_busy_late", 32'(busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_active", 32'(active_pose), 32'd2);
    chk("t5_ch0", w(0), 32'd1300);
    chk("t5_ch1", w(1), 32'd2500);

    // 6: reset mid-ramp, then neutral table
    send(8'd1);
    ticks(21);
    chk("t6_mid_1800", w(0), 32'd1800);
    reset = 1'b1;
    #1;
    chk("t6_rst_ch0", w(0), 32'd1500);
    chk("t6_rst_ch1", w(1), 32'd1500);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_active", 32'(active_pose), 32'd0);
    chk("t6_rst_ready", 32'(bus.gesture_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'd1);
    tick();
    chk("t6_n2_done", 32'(done), 32'd0);
    tick();
    chk("t6_n3_done", 32'(done), 32'd1);
    chk("t6_ch0", w(0), 32'd1500);
    chk("t6_ch1", w(1), 32'd1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
